// File: rtl/stream_demux.sv
// stream_demux
//   Routes a single upstream valid/ready stream to one of two downstream
//   ports (A or B), chosen per word by in_sel. Each output port owns one
//   register slot, holding a data word and a valid flag. A full slot whose
//   consumer is ready counts as free, so a port can drain and refill on the
//   same edge and sustain one word per cycle.
//   A per-port 8-bit counter counts delivered words, modulo 256.
//
// Handshake rule (applies to every port): a word moves on a rising edge
// where valid=1 and ready=1. A valid word and its data stay stable while
// ready=0. in_ready depends combinationally on in_sel and on the state of
// the selected slot only. It never depends on in_valid.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   in_data   upstream word
//   in_sel    destination select (0 = A, 1 = B), qualified by in_valid
//   in_valid  upstream word valid
//   in_ready  upstream word accepted this cycle
//   a_data    port A word          b_data    port B word
//   a_valid   port A holds a word  b_valid   port B holds a word
//   a_ready   port A consumer ready b_ready  port B consumer ready
//   a_count   words delivered on A (mod 256)
//   b_count   words delivered on B (mod 256)
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
);

    logic a_free;
    logic b_free;
    logic a_hs;
    logic b_hs;
    logic a_load;
    logic b_load;

    always_comb begin
        a_hs     = a_valid && a_ready;
        b_hs     = b_valid && b_ready;
        // A full slot being drained this edge can take a new word on the same edge.
        a_free   = !a_valid || a_ready;
        b_free   = !b_valid || b_ready;
        in_ready = in_sel ? b_free : a_free;
        a_load   = in_valid && in_ready && !in_sel;
        b_load   = in_valid && in_ready && in_sel;
    end

    // Reset takes priority over every handshake. Words offered or held
    // during reset are discarded, and the counters do not advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_data  <= '0;
            a_valid <= 1'b0;
            b_data  <= '0;
            b_valid <= 1'b0;
            a_count <= 8'd0;
            b_count <= 8'd0;
        end else begin
            if (a_load) begin
                a_data  <= in_data;
                a_valid <= 1'b1;
            end else if (a_hs) begin
                a_valid <= 1'b0;
            end

            if (b_load) begin
                b_data  <= in_data;
                b_valid <= 1'b1;
            end else if (b_hs) begin
                b_valid <= 1'b0;
            end

            if (a_hs) begin
                a_count <= a_count + 8'd1;
            end
            if (b_hs) begin
                b_count <= b_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
//   Bench for stream_demux (WIDTH = 8).
//   Inputs change 1 time unit after the rising edge, and outputs are sampled
//   on the falling edge. The driver pushes each accepted word onto the
//   queue of its destination port. The monitor pops that queue on every
//   port handshake and compares the popped word with the port data.
module tb_stream_demux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [7:0]   a_count;
    logic [7:0]   b_count;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    int           a_cnt_m;
    int           b_cnt_m;
    int           total;
    int           bad;

    stream_demux #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic sel, input logic [W-1:0] d);
        if (sel) exp_b_q.push_back(d);
        else     exp_a_q.push_back(d);
    endtask

    // Offer one word and wait (bounded) for acceptance.
    task automatic send(input logic [W-1:0] d, input logic sel);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = sel;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                push_exp(sel, d);
                accepted = 1'b1;
            end
            step();
            if (accepted) break;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word 0x%0h never accepted", d);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            // The coming edge resets the block, so everything in flight is discarded.
            exp_a_q.delete();
            exp_b_q.delete();
            a_cnt_m = 0;
            b_cnt_m = 0;
        end else begin
            if (a_valid === 1'b1 && a_ready === 1'b1) begin
                check("a_count_track", {24'd0, a_count}, a_cnt_m % 256);
                if (exp_a_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_extra: got 0x%0h expected no word", a_data);
                end else begin
                    check("a_data", {24'd0, a_data}, {24'd0, exp_a_q.pop_front()});
                end
                a_cnt_m++;
            end
            if (b_valid === 1'b1 && b_ready === 1'b1) begin
                check("b_count_track", {24'd0, b_count}, b_cnt_m % 256);
                if (exp_b_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_extra: got 0x%0h expected no word", b_data);
                end else begin
                    check("b_data", {24'd0, b_data}, {24'd0, exp_b_q.pop_front()});
                end
                b_cnt_m++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        a_cnt_m  = 0;
        b_cnt_m  = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_a_valid", {31'd0, a_valid}, 0);
        check("rst_b_valid", {31'd0, b_valid}, 0);
        check("rst_a_count", {24'd0, a_count}, 0);
        check("rst_b_count", {24'd0, b_count}, 0);
        check("rst_a_data", {24'd0, a_data}, 0);
        check("rst_b_data", {24'd0, b_data}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        step();
        rst_n = 1'b1;

        // Route: 0x11 to A, 0x22 to B
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(8'h11, 1'b0);
        check("route_a_valid", {31'd0, a_valid}, 1);
        check("route_a_data", {24'd0, a_data}, 32'h11);
        send(8'h22, 1'b1);
        check("route_b_valid", {31'd0, b_valid}, 1);
        check("route_b_data", {24'd0, b_data}, 32'h22);
        check("route_a_drained", {31'd0, a_valid}, 0);
        step();
        check("route_b_drained", {31'd0, b_valid}, 0);
        check("route_a_count", {24'd0, a_count}, 1);
        check("route_b_count", {24'd0, b_count}, 1);

        // Backpressure on A: 0x33 held, 0x44 refused, then drain and refill on one edge
        a_ready = 1'b0;
        send(8'h33, 1'b0);
        check("bp_a_data", {24'd0, a_data}, 32'h33);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h44;
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        step();
        check("bp_hold_valid", {31'd0, a_valid}, 1);
        check("bp_hold_data", {24'd0, a_data}, 32'h33);
        a_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", {31'd0, in_ready}, 1);
        if (in_ready === 1'b1) push_exp(1'b0, 8'h44);
        step();
        in_valid = 1'b0;
        a_ready  = 1'b0;
        check("bp_refill_valid", {31'd0, a_valid}, 1);
        check("bp_refill_data", {24'd0, a_data}, 32'h44);
        check("bp_a_count", {24'd0, a_count}, 2);

        // Independence: A stalled and full, B still accepts and delivers
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("ind_in_ready", {31'd0, in_ready}, 1);
        if (in_ready === 1'b1) push_exp(1'b1, 8'h55);
        step();
        in_valid = 1'b0;
        check("ind_b_data", {24'd0, b_data}, 32'h55);
        check("ind_a_stall_data", {24'd0, a_data}, 32'h44);
        check("ind_a_stall_valid", {31'd0, a_valid}, 1);
        step();
        check("ind_b_count", {24'd0, b_count}, 2);
        check("ind_a_count", {24'd0, a_count}, 2);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;

        // Reset mid-stream: A holds 0x66; a word offered during reset is dropped
        send(8'h66, 1'b0);
        check("rms_a_held", {24'd0, a_data}, 32'h66);
        rst_n    = 1'b0;
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        check("rms_in_ready", {31'd0, in_ready}, 1);
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("rms_a_valid", {31'd0, a_valid}, 0);
        check("rms_b_valid", {31'd0, b_valid}, 0);
        check("rms_a_count", {24'd0, a_count}, 0);
        check("rms_b_count", {24'd0, b_count}, 0);
        step();
        step();
        check("rms_no_delivery", {24'd0, a_count}, 0);
        a_ready = 1'b0;

        // Streaming: 300 back-to-back words on B, first one on the first edge after reset
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'b1;
            in_data  = W'(i * 7 + 3);
            @(negedge clk);
            check("stream_in_ready", {31'd0, in_ready}, 1);
            if (i > 0) check("stream_no_bubble", {31'd0, b_valid}, 1);
            if (in_ready === 1'b1) push_exp(1'b1, in_data);
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_b_count", {24'd0, b_count}, 44);
        check("stream_a_count", {24'd0, a_count}, 0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = W'($urandom_range(0, 255));
            a_ready  = 1'($urandom_range(0, 1));
            b_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready === 1'b1) push_exp(in_sel, in_data);
            step();
        end
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        step();
        step();
        step();
        check("rand_a_empty", exp_a_q.size(), 0);
        check("rand_b_empty", exp_b_q.size(), 0);
        check("rand_a_count", {24'd0, a_count}, a_cnt_m % 256);
        check("rand_b_count", {24'd0, b_count}, b_cnt_m % 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Port: in_data  input  WIDTH  upstream data word.
REQ-005 Port: in_sel  input  1  destination select, qualified by in_valid: 0 routes to port A, 1 routes to port B.
REQ-006 Port: in_valid  input  1  upstream word and select are valid.
REQ-007 Port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 Port: a_data  output  WIDTH  port A data.
REQ-009 Port: a_valid  output  1  port A holds a word.
REQ-010 Port: a_ready  input  1  port A consumer accepts the word.
REQ-011 Port: b_data  output  WIDTH  port B data.
REQ-012 Port: b_valid  output  1  port B holds a word.
REQ-013 Port: b_ready  input  1  port B consumer accepts the word.
REQ-014 Port: a_count  output  8  number of words delivered on port A, modulo 256.
REQ-015 Port: b_count  output  8  number of words delivered on port B, modulo 256.

Function
REQ-016 Each output port SHALL own exactly one register slot: data plus valid flag.
REQ-017 The upstream handshake SHALL complete on a rising edge where in_valid=1 and in_ready=1.
REQ-018 Port X's slot SHALL be free when x_valid=0, or when x_valid=1 and x_ready=1 (drain and refill in the same cycle).
REQ-019 in_ready SHALL be combinational: equal to slot-A-free when in_sel=0 and slot-B-free when in_sel=1; the unselected port has no effect.
REQ-020 An accepted word SHALL load the selected slot: x_data <= in_data, x_valid <= 1.
REQ-021 Latency: a word accepted at edge N SHALL be visible on x_data/x_valid from edge N onward, i.e. one cycle after presentation.
REQ-022 Throughput: with x_ready held at 1, port X SHALL sustain one word per cycle with no bubbles.
REQ-023 A port handshake (x_valid=1 and x_ready=1) with no refill in the same cycle SHALL clear x_valid at that edge.
REQ-024 While x_valid=1 and x_ready=0, x_data and x_valid SHALL hold stable.
REQ-025 The unselected slot SHALL drain independently; simultaneous drain on A and B in one cycle is legal.
REQ-026 When in_valid=0, in_sel SHALL be ignored, and in_ready still SHALL reflect the current in_sel.
REQ-027 x_count SHALL increment by 1 on each port-X handshake, wrapping 255 -> 0 with no saturation or flag.
REQ-028 Data SHALL never be duplicated, dropped, or reordered within a port.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL set a_valid=0, b_valid=0, a_count=0, b_count=0, a_data=0 and b_data=0.
REQ-030 During reset, in_ready SHALL still follow REQ-019 using the cleared slots; any word offered in a reset cycle SHALL be discarded, not stored.
REQ-031 Reset asserted mid-transfer SHALL discard held words without a handshake and SHALL NOT increment the counters.
REQ-032 After reset deassertion, the first upstream handshake SHALL be possible on the first edge.

Verification
REQ-033 Route: send 0x11 (sel=0) then 0x22 (sel=1), with a_ready=b_ready=1 -> 0x11 appears on A and 0x22 on B, each one cycle after acceptance; a_count=1, b_count=1.
REQ-034 Backpressure: hold a_ready=0 and offer 0x33, then 0x44, both sel=0 -> 0x33 is held on A and in_ready=0 for 0x44; raise a_ready -> 0x33 drains, 0x44 loads on the same edge, and the order is preserved.
REQ-035 Independence: a_ready=0 with A full; offer 0x55 with sel=1 -> in_ready=1 and 0x55 is delivered on B while A stays stalled.
REQ-036 Streaming: 300 back-to-back words with sel=1 and b_ready=1 -> no bubbles; b_count=44 (300 mod 256) and a_count=0.
REQ-037 Reset mid-stream: A holds 0x66 with a_ready=0; assert rst_n=0 for one edge -> a_valid=0, both counts 0, and 0x66 is never delivered.
REQ-038 Random: randomized in_valid, in_sel, a_ready and b_ready over 10000 cycles, checked against a per-port FIFO scoreboard -> no loss, duplication or reordering, and counters match the scoreboard modulo 256.
